// File: rtl/riscv_exec_pkg.sv
// Shared constants for the RISC-V execute stage: ALU operation codes, ALUOp codes, PC increment.
package riscv_exec_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    localparam logic [1:0] ALUOP_MEM  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/riscv_alu_decode.sv
// Combinational ALU-control decode: ALUOp/funct3/funct7/opcode to a 3-bit ALU operation.
module riscv_alu_decode
    import riscv_exec_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic [6:0] opcode_i,
    output logic [2:0] operation_o
);

    // Only bit 5 of funct7/opcode distinguishes R-type sub from add/addi.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{funct7_i[6], funct7_i[4:0], opcode_i[6], opcode_i[4:0]};

    always_comb begin
        operation_o = OP_ADD;
        case (alu_op_i)
            ALUOP_MEM: operation_o = OP_ADD;
            ALUOP_BR:  operation_o = OP_SUB;
            ALUOP_FUNC: begin
                case (funct3_i)
                    3'b000:  operation_o = (opcode_i[5] && funct7_i[5]) ? OP_SUB : OP_ADD;
                    3'b001:  operation_o = OP_SLL;
                    3'b010:  operation_o = OP_SLT;
                    3'b100:  operation_o = OP_XOR;
                    3'b101:  operation_o = OP_SRL;
                    3'b110:  operation_o = OP_OR;
                    3'b111:  operation_o = OP_AND;
                    default: operation_o = OP_ADD;
                endcase
            end
            default:   operation_o = OP_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_exec_unit.sv
// Registered execute stage: ALU decode, 32-bit ALU with zero flag, PC+4 and branch target adders.
// Optional overflow flag output enabled by defining RISCV_EXEC_OVF_EN.
module riscv_exec_unit
    import riscv_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [6:0]      opcode,
    input  logic            alu_src,
    input  logic            branch,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
`ifdef RISCV_EXEC_OVF_EN
    output logic            ovf,
`endif
    output logic            out_valid,
    output logic [2:0]      operation,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_target,
    output logic            branch_taken
);

    localparam int SHW = $clog2(XLEN);

    logic [2:0]      op_d;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] result_d;
    logic            zero_d;
    logic [SHW-1:0]  shamt;

    logic            out_valid_q;
    logic [2:0]      operation_q;
    logic [XLEN-1:0] alu_result_q;
    logic            zero_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic [XLEN-1:0] pc_target_q;
    logic            branch_taken_q;

    riscv_alu_decode u_decode (
        .alu_op_i    (alu_op),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .opcode_i    (opcode),
        .operation_o (op_d)
    );

    assign op_b  = alu_src ? imm : rs2_data;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        result_d = '0;
        case (op_d)
            OP_ADD:  result_d = rs1_data + op_b;
            OP_SUB:  result_d = rs1_data - op_b;
            OP_AND:  result_d = rs1_data & op_b;
            OP_OR:   result_d = rs1_data | op_b;
            OP_XOR:  result_d = rs1_data ^ op_b;
            OP_SLT:  result_d = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            OP_SLL:  result_d = rs1_data << shamt;
            OP_SRL:  result_d = rs1_data >> shamt;
            default: result_d = '0;
        endcase
    end

    assign zero_d = (result_d == '0);

`ifdef RISCV_EXEC_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: sub behaves like add with B's sign inverted.
    always_comb begin
        ovf_d = 1'b0;
        if (op_d == OP_ADD)
            ovf_d = (rs1_data[XLEN-1] == op_b[XLEN-1]) && (result_d[XLEN-1] != rs1_data[XLEN-1]);
        else if (op_d == OP_SUB)
            ovf_d = (rs1_data[XLEN-1] != op_b[XLEN-1]) && (result_d[XLEN-1] != rs1_data[XLEN-1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf_q <= 1'b0;
        else      ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q    <= 1'b0;
            operation_q    <= '0;
            alu_result_q   <= '0;
            zero_q         <= 1'b0;
            pc_plus4_q     <= '0;
            pc_target_q    <= '0;
            branch_taken_q <= 1'b0;
        end else begin
            out_valid_q    <= in_valid;
            operation_q    <= op_d;
            alu_result_q   <= result_d;
            zero_q         <= zero_d;
            pc_plus4_q     <= pc + XLEN'(PC_INCR);
            pc_target_q    <= pc + imm;
            branch_taken_q <= branch & zero_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign operation    = operation_q;
    assign alu_result   = alu_result_q;
    assign zero         = zero_q;
    assign pc_plus4     = pc_plus4_q;
    assign pc_target    = pc_target_q;
    assign branch_taken = branch_taken_q;

endmodule

// File: tb/tb_riscv_exec_unit.sv
// Scoreboard bench for riscv_exec_unit: directed and random vectors against a behavioural model.
module tb_riscv_exec_unit;

    typedef struct {
        logic        v;
        logic [1:0]  alu_op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  opc;
        logic        src;
        logic        br;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
    } stim_t;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] res;
        logic        z;
        logic [31:0] p4;
        logic [31:0] pt;
        logic        bt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [6:0]  opcode = '0;
    logic        alu_src = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc = '0;
    logic        out_valid;
    logic [2:0]  operation;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] pc_plus4;
    logic [31:0] pc_target;
    logic        branch_taken;
`ifdef RISCV_EXEC_OVF_EN
    logic        ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    riscv_exec_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .alu_op       (alu_op),
        .funct3       (funct3),
        .funct7       (funct7),
        .opcode       (opcode),
        .alu_src      (alu_src),
        .branch       (branch),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .pc           (pc),
`ifdef RISCV_EXEC_OVF_EN
        .ovf          (ovf),
`endif
        .out_valid    (out_valid),
        .operation    (operation),
        .alu_result   (alu_result),
        .zero         (zero),
        .pc_plus4     (pc_plus4),
        .pc_target    (pc_target),
        .branch_taken (branch_taken)
    );

    always #5 clk = ~clk;

    // Reference model: works from instruction meaning (named op, integer arithmetic).
    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic [31:0] bo;
        longint sa, sb_, wide;
        bo = s.src ? s.imm : s.b;
        sa = longint'($signed(s.a));
        sb_ = longint'($signed(bo));
        if (s.alu_op == 2'd1)
            e.op = 3'd1;
        else if (s.alu_op != 2'd2)
            e.op = 3'd0;
        else begin
            case (s.f3)
                3'd0: e.op = (s.opc[5] && s.f7[5]) ? 3'd1 : 3'd0;
                3'd1: e.op = 3'd6;
                3'd2: e.op = 3'd5;
                3'd4: e.op = 3'd4;
                3'd5: e.op = 3'd7;
                3'd6: e.op = 3'd3;
                3'd7: e.op = 3'd2;
                default: e.op = 3'd0;
            endcase
        end
        e.ovf = 1'b0;
        case (e.op)
            3'd0: begin
                wide = sa + sb_;
                e.res = s.a + bo;
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'd1: begin
                wide = sa - sb_;
                e.res = s.a - bo;
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'd2: e.res = s.a & bo;
            3'd3: e.res = s.a | bo;
            3'd4: e.res = s.a ^ bo;
            3'd5: e.res = (sa < sb_) ? 32'd1 : 32'd0;
            3'd6: e.res = s.a << (bo % 32);
            default: e.res = s.a >> (bo % 32);
        endcase
        e.v  = s.v;
        e.z  = (e.res == 32'd0);
        e.p4 = s.pc + 32'd4;
        e.pt = s.pc + s.imm;
        e.bt = s.br && e.z;
        return e;
    endfunction

    function automatic stim_t mk(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [6:0] opc, input logic src, input logic br,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] p);
        stim_t s;
        s.v = 1'b1; s.alu_op = aop; s.f3 = f3; s.f7 = f7; s.opc = opc;
        s.src = src; s.br = br; s.a = a; s.b = b; s.imm = im; s.pc = p;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        in_valid = s.v; alu_op = s.alu_op; funct3 = s.f3; funct7 = s.f7; opcode = s.opc;
        alu_src = s.src; branch = s.br; rs1_data = s.a; rs2_data = s.b; imm = s.imm; pc = s.pc;
        sb.push_back(model(s));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_operation"}, {29'd0, operation}, 32'd0);
        chk({tag, "_alu_result"}, alu_result, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero}, 32'd0);
        chk({tag, "_pc_plus4"}, pc_plus4, 32'd0);
        chk({tag, "_pc_target"}, pc_target, 32'd0);
        chk({tag, "_branch_taken"}, {31'd0, branch_taken}, 32'd0);
`ifdef RISCV_EXEC_OVF_EN
        chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
`endif
    endtask

    // Monitor: one scoreboard entry per clocked cycle while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
                if (e.v) begin
                    chk("operation", {29'd0, operation}, {29'd0, e.op});
                    chk("alu_result", alu_result, e.res);
                    chk("zero", {31'd0, zero}, {31'd0, e.z});
                    chk("pc_plus4", pc_plus4, e.p4);
                    chk("pc_target", pc_target, e.pt);
                    chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.bt});
`ifdef RISCV_EXEC_OVF_EN
                    chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        #2;
        check_all_zero("reset_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        drive(mk(2'b10, 3'b000, 7'h00, 7'h33, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h0));
        drive(mk(2'b10, 3'b000, 7'h20, 7'h33, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h4));
        drive(mk(2'b01, 3'b000, 7'h00, 7'h63, 1'b0, 1'b1, 32'h1234, 32'h1234, 32'h20, 32'h100));
        drive(mk(2'b01, 3'b000, 7'h00, 7'h63, 1'b0, 1'b1, 32'h1234, 32'h1235, 32'h20, 32'h100));
        drive(mk(2'b00, 3'b010, 7'h00, 7'h03, 1'b1, 1'b0, 32'h1000, 32'h0, 32'hFFFFFFFC, 32'h200));
        drive(mk(2'b10, 3'b010, 7'h00, 7'h33, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0));
        drive(mk(2'b10, 3'b001, 7'h00, 7'h33, 1'b0, 1'b0, 32'd1, 32'h21, 32'd0, 32'h0));
        drive(mk(2'b10, 3'b101, 7'h00, 7'h33, 1'b0, 1'b0, 32'h80000000, 32'd31, 32'd0, 32'h0));
        drive(mk(2'b10, 3'b111, 7'h00, 7'h33, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'h0));
        drive(mk(2'b10, 3'b110, 7'h00, 7'h33, 1'b0, 1'b0, 32'hF000, 32'h000F, 32'd0, 32'h0));
        drive(mk(2'b10, 3'b100, 7'h00, 7'h33, 1'b0, 1'b0, 32'hFFFF, 32'hFFFF, 32'd0, 32'h0));
        drive(mk(2'b10, 3'b011, 7'h00, 7'h33, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'h0));
        drive(mk(2'b10, 3'b000, 7'h20, 7'h13, 1'b1, 1'b0, 32'd10, 32'd0, 32'h400, 32'h0));
        drive(mk(2'b11, 3'b000, 7'h20, 7'h33, 1'b0, 1'b0, 32'd9, 32'd1, 32'd0, 32'h0));
        drive(mk(2'b00, 3'b000, 7'h00, 7'h33, 1'b0, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFC));
        drive(mk(2'b01, 3'b000, 7'h00, 7'h63, 1'b0, 1'b0, 32'h80000000, 32'd1, 32'd0, 32'h0));
        s = mk(2'b00, 3'b000, 7'h00, 7'h33, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 32'h0);
        s.v = 1'b0;
        drive(s);

        for (int i = 0; i < 300; i++) begin
            s.v      = ($urandom_range(0, 4) != 0);
            s.alu_op = 2'($urandom_range(0, 3));
            s.f3     = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: s.f7 = 7'h00;
                1: s.f7 = 7'h20;
                default: s.f7 = 7'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: s.opc = 7'h33;
                1: s.opc = 7'h13;
                default: s.opc = 7'($urandom);
            endcase
            s.src = 1'($urandom);
            s.br  = 1'($urandom);
            s.a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            s.b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            s.imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 4) == 0) s.b = s.a;
            s.pc  = $urandom;
            drive(s);
        end

        drive(mk(2'b10, 3'b110, 7'h00, 7'h33, 1'b0, 1'b0, 32'h12345678, 32'h1, 32'h40, 32'h300));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        in_valid = 1'b1; rs1_data = 32'h55; rs2_data = 32'h1; pc = 32'h1000; imm = 32'h8;
        alu_op = 2'b00; alu_src = 1'b0; branch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_hold");

        @(negedge clk);
        rst = 1'b1;
        drive(mk(2'b10, 3'b000, 7'h20, 7'h33, 1'b0, 1'b1, 32'hABC, 32'hABC, 32'h10, 32'h2000));
        drive(mk(2'b00, 3'b000, 7'h00, 7'h33, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h0, 32'h0));
        @(negedge clk);
        in_valid = 1'b0;

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_exec_unit.md
Name: riscv_exec_unit

Overview:
- Execute stage of the single-cycle RISC-V core.
- Combines three functions:
  - ALU-control decode (ALUOp/funct3/funct7/opcode to a 3-bit operation).
  - The 32-bit ALU with zero flag.
  - The two PC adders: PC+4 and PC+immediate branch target.
- All results are captured in one output register stage, so the block presents execute results one clock after inputs are sampled.

Parameters:
- XLEN, 32, datapath width. Shift amount uses the low log2(XLEN) bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  inputs valid this cycle
- alu_op  input  2  00 load/store, 01 branch, 10 R/I-type decode, 11 reserved
- funct3  input  3  instruction[14:12]
- funct7  input  7  instruction[31:25]
- opcode  input  7  instruction[6:0]
- alu_src  input  1  0: operand B = rs2_data, 1: operand B = imm
- branch  input  1  instruction is a conditional branch
- rs1_data  input  XLEN  operand A
- rs2_data  input  XLEN  register operand B
- imm  input  XLEN  sign-extended immediate
- pc  input  XLEN  current PC
- out_valid  output  1  registered in_valid
- operation  output  3  registered decoded ALU operation
- alu_result  output  XLEN  registered ALU result
- zero  output  1  registered (alu_result == 0)
- pc_plus4  output  XLEN  registered pc + 4
- pc_target  output  XLEN  registered pc + imm
- branch_taken  output  1  registered branch & zero

Behaviour:
- Reset: while rst=0, all outputs are 0, including zero=0. Reset assertion clears asynchronously. Reset release is synchronous to the next clk edge.
- Latency: one cycle. On each rising edge with rst=1, every output register loads its combinational value.
- Registers load every cycle, independent of in_valid. out_valid only flags whether the data is meaningful.
- Operation encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- ALU-control decode:
  - alu_op 00 gives ADD.
  - alu_op 01 gives SUB.
  - alu_op 11 gives ADD.
  - alu_op 10 decodes on funct3:
    - 000: SUB if opcode[5]=1 and funct7[5]=1 (R-type sub), else ADD. addi with imm[10]=1 is therefore ADD.
    - 001 SLL; 010 SLT; 100 XOR; 101 SRL; 110 OR; 111 AND.
    - 011 gives ADD (unsupported SLTU).
- Operand B: alu_src ? imm : rs2_data.
- ADD/SUB are modulo 2^XLEN; carry out is discarded.
- SLT: signed compare; result is 1 when A<B, else 0 (zero-extended).
- SLL/SRL: logical shifts by B[4:0]; upper bits of B are ignored.
- zero is computed from the ALU result before registering.
- pc_plus4 = pc + 4 and pc_target = pc + imm, both wrapping modulo 2^XLEN.
- branch_taken = branch & zero. It is meaningful only with alu_op=01.
- Simultaneous reset and clock edge: reset wins.

Optional Feature:
- Macro: RISCV_EXEC_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, registered, reset 0).
  - ovf is set for ADD when the operands have equal signs and the result sign differs.
  - ovf is set for SUB when the operand signs differ and the result sign differs from A.
  - ovf is 0 for all other operations.
- When undefined: no ovf port and no overflow logic.

Decomposition:
- Shared package riscv_exec_pkg holds:
  - The 3-bit operation localparams (OP_ADD..OP_SRL).
  - The ALUOp codes (ALUOP_MEM, ALUOP_BR, ALUOP_FUNC).
  - The constant PC_INCR=4.
- One natural sub-module: riscv_alu_decode, a purely combinational ALUOp/funct decode producing operation.
- The ALU, adders and output register stay inline.

Test Plan:
- Reset: rst=0 mid-run gives all outputs 0 immediately, before any clock edge. After release, the first edge loads data.
- R-type add/sub:
  - alu_op=10, funct3=000, opcode=0110011, funct7=0000000, A=5, B=7 gives alu_result=12, zero=0, operation=000.
  - Same with funct7=0100000 gives 0xFFFFFFFE, operation=001.
- Branch: alu_op=01, branch=1, A=B=0x1234, pc=0x100, imm=0x20 gives zero=1, branch_taken=1, pc_target=0x120, pc_plus4=0x104. With B=0x1235, branch_taken=0.
- Load address: alu_op=00, alu_src=1, A=0x1000, imm=0xFFFFFFFC gives alu_result=0x00000FFC.
- Logic/SLT/shift:
  - SLT A=0xFFFFFFFF, B=1 gives 1.
  - SLL A=1, B=0x21 gives 2.
  - SRL A=0x80000000, B=31 gives 1.
  - AND 0xF0F0 & 0x0FF0 gives 0x00F0.
- Overflow (RISCV_EXEC_OVF_EN): ADD 0x7FFFFFFF+1 gives ovf=1, result 0x80000000. pc=0xFFFFFFFC gives pc_plus4=0.
